// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with a valid/ready byte output.
// The serial input is double-flopped. The start bit is qualified at half a bit.
// Each data bit and the stop bit are sampled at the centre of their bit period.
// Framing and overrun conditions are reported as single-cycle pulses.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
// That option adds a PARITY state and a parity_err_o output port.
module uart_rx #(
  parameter int BIT_RATE = 9600,
  parameter int CLK_HZ   = 100_000_000
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err_o,
  output logic       overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err_o
`endif
);

  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             tick;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             perr_q, perr_d;
`endif

  // Bit-period tick: half a bit while qualifying the start bit, a full bit otherwise.
  always_comb begin
    tick = (state_q == S_START) ? (cnt_q == HALF_LAST) : (cnt_q == BIT_LAST);
  end

  // Next-state logic for the synchronizer, the receive FSM and the output handshake.
  always_comb begin
    // NOTE: every _d gets a default first, so no path can leave one unassigned and infer a latch.
    sync1_d   = rx_i;
    rx_s_d    = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    // The consumer takes the held byte. A load on the same cycle overrides this below.
    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (tick) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;               // line back high at mid start bit: glitch
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rx_s_q};   // even parity: total ones must be even
          state_d   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else
`endif
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;                 // previous byte still unconsumed: drop new one
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered state, with a synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!nreset_i) begin
      sync1_q   <= 1'b1;                    // idle-high so reset never looks like a start bit
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data_o   = data_q;
  assign valid       = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule
